led_seq_ctrl: RTL
=================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter BASE_DIV, default 8388608: slowest step period in CLK cycles; power of two, >=8.
REQ-002 Parameter SWEEPS, default 2: complete sweeps per pattern in auto mode; range 1..15.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 RST  input  1  reset; asynchronous and active-high.
REQ-005 EN  input  1  level; 1 = run sequencer, 0 = idle.
REQ-006 UP  input  1  one-cycle pulse (already debounced); request next pattern.
REQ-007 DOWN  input  1  one-cycle pulse (already debounced); request previous pattern.
REQ-008 AUTO  input  1  level; 1 = patterns advance automatically.
REQ-009 SPEED  input  2  step period = BASE_DIV >> SPEED cycles.
REQ-010 PATTERN  output  2  active pattern: 0 bounce, 1 left, 2 right; 3 never driven.
REQ-011 STEP  output  3  current step index within the sweep.
REQ-012 TICK  output  1  one-cycle step strobe.
REQ-013 CHANGE  output  1  one-cycle pulse in the cycle PATTERN takes a new value.
REQ-014 PENDING  output  1  a manual request is waiting for sweep end.
REQ-015 LED  output  4  decoded LED drive.

Function
REQ-016 FSM states: IDLE, RUN, PEND; state register and all outputs are registered except LED.
REQ-017 IDLE->RUN when EN=1; on entry, prescaler=0 and STEP=0.
REQ-018 Any state->IDLE when EN=0: STEP=0, pending request discarded, PATTERN retained, prescaler held at 0.
REQ-019 Prescaler counts 0..(BASE_DIV>>SPEED)-1 in RUN/PEND; TICK=1 for the cycle after the terminal count; with SPEED=3 and BASE_DIV=8, TICK is 1 every cycle.
REQ-020 SPEED is registered; any change clears the prescaler, and no TICK is issued in that cycle.
REQ-021 Last step: 5 for pattern 0, 3 for patterns 1 and 2; sweep_end = TICK and STEP at last step.
REQ-022 On TICK and not sweep_end: STEP increments. On sweep_end with no pattern change: STEP wraps to 0.
REQ-023 Valid request: exactly one of UP/DOWN high. UP and DOWN together are ignored.
REQ-024 A valid request in RUN latches its direction and moves to PEND. In PEND, a newer valid request overwrites the latched direction.
REQ-025 In PEND at sweep_end: PATTERN updates (UP: 0->1->2->0; DOWN: 0->2->1->0), STEP=0, CHANGE=1, PENDING=0, state->RUN.
REQ-026 A request arriving in the same cycle as sweep_end is latched and is not applied until the following sweep_end.
REQ-027 Sweep counter increments on each sweep_end in RUN with AUTO=1. It clears on any PATTERN change, when AUTO=0, and in IDLE.
REQ-028 In RUN with AUTO=1, the sweep_end that brings the count to SWEEPS advances PATTERN as UP and asserts CHANGE. Manual requests (PEND) take priority over the auto advance.
REQ-029 PENDING=1 exactly while the state is PEND.
REQ-030 LED decode is combinational from PATTERN/STEP; 0000 in IDLE.
  - Bounce steps 0..5: 0001,0010,0100,1000,0100,0010.
  - Left steps 0..3: 0001,0010,0100,1000.
  - Right steps 0..3: 1000,0100,0010,0001.

Reset
REQ-031 RST=1 immediately forces:
  - state IDLE;
  - PATTERN=0, STEP=0, TICK=0, CHANGE=0, PENDING=0, LED=0000;
  - prescaler=0, sweep counter=0, pending direction cleared.
REQ-032 RST asserted mid-operation, including in PEND, discards all state. After release, the block behaves as after power-up.

Verification (BASE_DIV=8, SWEEPS=2, SPEED=0 unless stated)
REQ-033 Release reset, EN=1 -> LED 0001; TICK every 8 cycles; LED sequence 0010,0100,1000,0100,0010,0001 repeating.
REQ-034 UP at step 2 of pattern 0 -> PENDING=1, pattern unchanged; at the 6th TICK, PATTERN=1, STEP=0, CHANGE pulse, LED 0001, PENDING=0.
REQ-035 Each of the following, applied in pattern 0 -> required response:
  - DOWN -> pattern 2 at sweep end.
  - UP and DOWN in the same cycle -> no PENDING.
  - UP then DOWN mid-sweep -> pattern 2.
  - UP on the sweep_end cycle -> applied one sweep later.
REQ-036 AUTO=1 from reset -> PATTERN 0->1 after 12 TICKs, 1->2 after 8 more, 2->0 after 8 more; CHANGE pulses at each change.
REQ-037 Each of the following -> required response:
  - SPEED=3 -> TICK every cycle.
  - SPEED 0->1 mid-count -> prescaler restarts; next TICK 4 cycles later.
REQ-038 Each of the following -> required response:
  - EN=0 while in PEND -> LED 0000, PENDING=0, PATTERN kept.
  - RST mid-run -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: prescaled step strobe, three sweep patterns (bounce/left/right),
// manual next/previous requests applied at sweep end, optional automatic pattern advance.
module led_seq_ctrl #(
  parameter int unsigned BASE_DIV = 8388608,
  parameter int unsigned SWEEPS   = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       UP,
  input  logic       DOWN,
  input  logic       AUTO,
  input  logic [1:0] SPEED,
  output logic [1:0] PATTERN,
  output logic [2:0] STEP,
  output logic       TICK,
  output logic       CHANGE,
  output logic       PENDING,
  output logic [3:0] LED
);

  localparam int unsigned PW = $clog2(BASE_DIV);

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      speed_q, speed_d;
  logic [1:0]      pattern_q, pattern_d;
  logic [2:0]      step_q, step_d;
  logic            tick_q, tick_d;
  logic            change_q, change_d;
  logic            dir_q, dir_d;       // latched request direction, 1 = up
  logic [3:0]      sweep_q, sweep_d;

  logic            valid_req;
  logic [2:0]      last_step;
  logic            sweep_end;
  logic [PW-1:0]   presc_term;

  assign valid_req  = UP ^ DOWN;
  assign last_step  = (pattern_q == 2'd0) ? 3'd5 : 3'd3;
  assign sweep_end  = tick_q && (step_q == last_step);
  assign presc_term = PW'((BASE_DIV >> speed_q) - 1);

  // Cyclic pattern step: up 0->1->2->0, down 0->2->1->0.
  function automatic logic [1:0] next_pat(input logic [1:0] p, input logic up);
    logic [1:0] r;
    case (p)
      2'd0:    r = up ? 2'd1 : 2'd2;
      2'd1:    r = up ? 2'd2 : 2'd0;
      2'd2:    r = up ? 2'd0 : 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      speed_q   <= '0;
      pattern_q <= '0;
      step_q    <= '0;
      tick_q    <= 1'b0;
      change_q  <= 1'b0;
      dir_q     <= 1'b0;
      sweep_q   <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      speed_q   <= speed_d;
      pattern_q <= pattern_d;
      step_q    <= step_d;
      tick_q    <= tick_d;
      change_q  <= change_d;
      dir_q     <= dir_d;
      sweep_q   <= sweep_d;
    end
  end

  // Next-state logic; EN low forces idle from anywhere.
  always_comb begin
    state_d = state_q;
    if (!EN) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  state_d = StRun;
        StRun:   if (valid_req) state_d = StPend;
        // A request coinciding with sweep end stays pending for the next sweep.
        StPend:  if (sweep_end && !valid_req) state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // Prescaler, step, pattern, request and sweep-count updates.
  always_comb begin
    presc_d   = presc_q;
    speed_d   = SPEED;
    pattern_d = pattern_q;
    step_d    = step_q;
    tick_d    = 1'b0;
    change_d  = 1'b0;
    dir_d     = dir_q;
    sweep_d   = sweep_q;
    if (!EN || state_q == StIdle) begin
      presc_d = '0;
      step_d  = '0;
      dir_d   = 1'b0;
      sweep_d = '0;
    end else begin
      if (SPEED != speed_q) begin
        presc_d = '0;
      end else if (presc_q == presc_term) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end

      if (valid_req) dir_d = UP;
      if (!AUTO) sweep_d = '0;

      if (tick_q && !sweep_end) begin
        step_d = step_q + 3'd1;
      end else if (sweep_end) begin
        step_d = '0;
        if (state_q == StPend) begin
          // Manual request wins over the automatic advance.
          pattern_d = next_pat(pattern_q, dir_q);
          change_d  = 1'b1;
          sweep_d   = '0;
        end else if (AUTO) begin
          if (sweep_q == 4'(SWEEPS - 1)) begin
            pattern_d = next_pat(pattern_q, 1'b1);
            change_d  = 1'b1;
            sweep_d   = '0;
          end else begin
            sweep_d = sweep_q + 4'd1;
          end
        end
      end
    end
  end

  // LED decode from pattern and step; dark while idle.
  always_comb begin
    LED = 4'b0000;
    if (state_q != StIdle) begin
      case (pattern_q)
        2'd0: begin
          case (step_q)
            3'd0:    LED = 4'b0001;
            3'd1:    LED = 4'b0010;
            3'd2:    LED = 4'b0100;
            3'd3:    LED = 4'b1000;
            3'd4:    LED = 4'b0100;
            3'd5:    LED = 4'b0010;
            default: LED = 4'b0000;
          endcase
        end
        2'd1:    LED = 4'b0001 << step_q[1:0];
        2'd2:    LED = 4'b1000 >> step_q[1:0];
        default: LED = 4'b0000;
      endcase
    end
  end

  assign PATTERN = pattern_q;
  assign STEP    = step_q;
  assign TICK    = tick_q;
  assign CHANGE  = change_q;
  assign PENDING = (state_q == StPend);

endmodule
